// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared definitions for the M-extension divide/multiply
//                controllers: funct3 codes, controller FSM encoding and
//                width-sized helper constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // RISC-V M-extension funct3 codes for the divide group
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    // Helpers below are computed at this width and cast down by the user
    localparam int MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LAUNCH   = 3'd1,
        ST_DIV_WAIT = 3'd2,
        ST_RESP     = 3'd3,
        ST_DRAIN    = 3'd4
    } div_state_e;

    // Most-negative two's-complement value of a w-bit word
    function automatic logic [MAX_WIDTH-1:0] most_neg(input int w);
        return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (w - 1);
    endfunction

    // All-ones value of a w-bit word
    function automatic logic [MAX_WIDTH-1:0] all_ones(input int w);
        if (w >= MAX_WIDTH) begin
            return {MAX_WIDTH{1'b1}};
        end
        return ({{(MAX_WIDTH-1){1'b0}}, 1'b1} << w) - {{(MAX_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_div_ctrl_if
//  Description : Bundles the core request/response handshake and the divider
//                launch/return signals of the divide controller. The slave
//                modport is the controller; master is the surrounding system.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mdu_div_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    // Core request side
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_funct3;
    logic [WIDTH-1:0] i_rs1;
    logic [WIDTH-1:0] i_rs2;
    logic [TAG_W-1:0] i_tag;
    logic             i_kill;
    // Writeback side
    logic             o_valid;
    logic             i_res_ready;
    logic [WIDTH-1:0] o_result;
    logic [TAG_W-1:0] o_tag;
    logic             o_illegal;
    // Divider side
    logic             o_div_valid;
    logic [WIDTH-1:0] o_dividend;
    logic [WIDTH-1:0] o_divisor;
    logic             o_div_sign;
    logic             i_div_ready;
    logic [WIDTH-1:0] i_div_q;
    logic [WIDTH-1:0] i_div_r;

    modport slave (
        input  i_valid, i_funct3, i_rs1, i_rs2, i_tag, i_kill,
        input  i_res_ready, i_div_ready, i_div_q, i_div_r,
        output o_ready, o_valid, o_result, o_tag, o_illegal,
        output o_div_valid, o_dividend, o_divisor, o_div_sign
    );

    modport master (
        output i_valid, i_funct3, i_rs1, i_rs2, i_tag, i_kill,
        output i_res_ready, i_div_ready, i_div_q, i_div_r,
        input  o_ready, o_valid, o_result, o_tag, o_illegal,
        input  o_div_valid, o_dividend, o_divisor, o_div_sign
    );

endinterface
`default_nettype wire

// File: rtl/mdu_div_special.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_div_special
//  Description : Combinational detector for divide requests that resolve
//                without the iterative divider: non-divide funct3 (illegal),
//                divide-by-zero and signed overflow (MIN / -1).
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_div_special
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] rs1_i,
    input  wire logic [WIDTH-1:0] rs2_i,
    input  wire logic [2:0]       funct3_i,
    output logic                  is_illegal_o,
    output logic                  is_special_o,
    output logic [WIDTH-1:0]      special_result_o
);

    localparam logic [WIDTH-1:0] C_MOST_NEG = WIDTH'(most_neg(WIDTH));
    localparam logic [WIDTH-1:0] C_ALL_ONES = WIDTH'(all_ones(WIDTH));

    logic w_signed;
    logic w_rem;
    logic w_div_zero;
    logic w_overflow;

    assign w_signed   = ~funct3_i[0];
    assign w_rem      = funct3_i[1];
    assign w_div_zero = (rs2_i == '0);
    assign w_overflow = w_signed && (rs1_i == C_MOST_NEG) && (rs2_i == C_ALL_ONES);

    // Priority: illegal opcode, then divide-by-zero, then signed overflow
    always_comb begin
        is_illegal_o     = 1'b0;
        is_special_o     = 1'b0;
        special_result_o = '0;
        if (!funct3_i[2]) begin
            is_illegal_o = 1'b1;
            is_special_o = 1'b1;
        end else if (w_div_zero) begin
            is_special_o     = 1'b1;
            special_result_o = w_rem ? rs1_i : C_ALL_ONES;
        end else if (w_overflow) begin
            is_special_o     = 1'b1;
            special_result_o = w_rem ? '0 : rs1_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_div_ctrl
//  Description : Issue/response controller between M-extension dispatch and
//                the iterative divider. Resolves special cases on a fast
//                path, launches the divider otherwise, holds the result for
//                writeback and drains a killed in-flight division (the
//                divider cannot be aborted).
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_div_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  wire logic      i_clk,
    input  wire logic      i_rst_n,
    mdu_div_ctrl_if.slave  bus
);

    div_state_e       state_q,    state_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q,  divisor_d;
    logic             sign_q,     sign_d;
    logic             rem_sel_q,  rem_sel_d;
    logic [TAG_W-1:0] tag_q,      tag_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic             illegal_q,  illegal_d;

    logic             w_is_illegal;
    logic             w_is_special;
    logic [WIDTH-1:0] w_special_result;

    // Special cases are judged on the raw request so the fast path costs one cycle
    mdu_div_special #(
        .WIDTH (WIDTH)
    ) u_special (
        .rs1_i            (bus.i_rs1),
        .rs2_i            (bus.i_rs2),
        .funct3_i         (bus.i_funct3),
        .is_illegal_o     (w_is_illegal),
        .is_special_o     (w_is_special),
        .special_result_o (w_special_result)
    );

    // State and datapath registers; async reset clears every output source
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            sign_q     <= 1'b0;
            rem_sel_q  <= 1'b0;
            tag_q      <= '0;
            result_q   <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            sign_q     <= sign_d;
            rem_sel_q  <= rem_sel_d;
            tag_q      <= tag_d;
            result_q   <= result_d;
            illegal_q  <= illegal_d;
        end
    end

    // Next-state logic; operands only change on accept so they stay stable
    // for the divider from LAUNCH through DIV_WAIT/DRAIN
    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        sign_d     = sign_q;
        rem_sel_d  = rem_sel_q;
        tag_d      = tag_q;
        result_d   = result_q;
        illegal_d  = illegal_q;

        unique case (state_q)
            ST_IDLE: begin
                // Kill is ignored here: a same-cycle request is still taken
                if (bus.i_valid) begin
                    dividend_d = bus.i_rs1;
                    divisor_d  = bus.i_rs2;
                    sign_d     = ~bus.i_funct3[0];
                    rem_sel_d  = bus.i_funct3[1];
                    tag_d      = bus.i_tag;
                    illegal_d  = w_is_illegal;
                    result_d   = w_special_result;
                    state_d    = w_is_special ? ST_RESP : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // The start pulse goes out this cycle, so a kill must drain
                state_d = bus.i_kill ? ST_DRAIN : ST_DIV_WAIT;
            end
            ST_DIV_WAIT: begin
                if (bus.i_kill) begin
                    // Divider finishing in the kill cycle has nothing left to drain
                    state_d = bus.i_div_ready ? ST_IDLE : ST_DRAIN;
                end else if (bus.i_div_ready) begin
                    result_d  = rem_sel_q ? bus.i_div_r : bus.i_div_q;
                    illegal_d = 1'b0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.i_kill || bus.i_res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (bus.i_div_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.o_ready     = (state_q == ST_IDLE);
    assign bus.o_valid     = (state_q == ST_RESP);
    assign bus.o_result    = result_q;
    assign bus.o_tag       = tag_q;
    assign bus.o_illegal   = illegal_q && (state_q == ST_RESP);
    assign bus.o_div_valid = (state_q == ST_LAUNCH);
    assign bus.o_dividend  = dividend_q;
    assign bus.o_divisor   = divisor_q;
    assign bus.o_div_sign  = sign_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_div_ctrl
//  Description : Self-checking bench for mdu_div_ctrl. Plays core, writeback
//                and divider; expected results come from RISC-V division
//                rules evaluated with plain arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_div_ctrl;

    localparam int W  = 32;
    localparam int TW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_div_ctrl_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    mdu_div_ctrl #(.WIDTH(W), .TAG_W(TW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // True quotient/remainder, truncating toward zero
    function automatic void div_truth(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] q, output logic [31:0] r);
        if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Architectural result of a request, and whether it bypasses the divider
    function automatic void ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                      output logic fast, output logic ill, output logic [31:0] res);
        logic [31:0] q;
        logic [31:0] r;
        logic        sgn;
        sgn  = !f3[0];
        ill  = !f3[2];
        fast = 1'b1;
        if (ill) begin
            res = 32'h0;
        end else if (b == 32'h0) begin
            res = f3[1] ? a : 32'hFFFF_FFFF;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = f3[1] ? 32'h0 : a;
        end else begin
            fast = 1'b0;
            div_truth(sgn, a, b, q, r);
            res = f3[1] ? r : q;
        end
    endfunction

    // One full request: accept, optional divider round trip, held response
    task automatic run_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [TW-1:0] tag, input int lat, input int hold);
        logic        fast;
        logic        ill;
        logic [31:0] exp;
        logic [31:0] q;
        logic [31:0] r;
        ref_model(f3, a, b, fast, ill, exp);
        @(negedge clk);
        chk("ready_idle", bus.o_ready, 1);
        bus.i_valid  = 1'b1;
        bus.i_funct3 = f3;
        bus.i_rs1    = a;
        bus.i_rs2    = b;
        bus.i_tag    = tag;
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_rs1   = $urandom;
        bus.i_rs2   = $urandom;
        bus.i_tag   = TW'($urandom);
        if (fast) begin
            chk("fast_no_start", bus.o_div_valid, 0);
        end else begin
            chk("start_pulse", bus.o_div_valid, 1);
            chk("div_sign", bus.o_div_sign, !f3[0]);
            chk("dividend", bus.o_dividend, a);
            chk("divisor", bus.o_divisor, b);
            chk("no_early_valid", bus.o_valid, 0);
            @(negedge clk);
            chk("start_once", bus.o_div_valid, 0);
            repeat (lat) @(negedge clk);
            chk("operands_stable", bus.o_dividend, a);
            div_truth(!f3[0], a, b, q, r);
            bus.i_div_ready = 1'b1;
            bus.i_div_q     = q;
            bus.i_div_r     = r;
            @(negedge clk);
            bus.i_div_ready = 1'b0;
            bus.i_div_q     = $urandom;
            bus.i_div_r     = $urandom;
        end
        chk("resp_valid", bus.o_valid, 1);
        chk("resp_result", bus.o_result, exp);
        chk("resp_tag", bus.o_tag, tag);
        chk("resp_illegal", bus.o_illegal, ill);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", bus.o_valid, 1);
            chk("hold_result", bus.o_result, exp);
            chk("hold_not_ready", bus.o_ready, 0);
        end
        bus.i_res_ready = 1'b1;
        @(negedge clk);
        bus.i_res_ready = 1'b0;
        chk("post_hs_valid", bus.o_valid, 0);
        chk("post_hs_illegal", bus.o_illegal, 0);
        chk("post_hs_ready", bus.o_ready, 1);
    endtask

    // Kill after launch; where==0 kills in LAUNCH, 1 in DIV_WAIT, 2 in DIV_WAIT with same-cycle done
    task automatic run_kill(input int where);
        @(negedge clk);
        bus.i_valid  = 1'b1;
        bus.i_funct3 = 3'b100;
        bus.i_rs1    = 32'd50;
        bus.i_rs2    = 32'd5;
        bus.i_tag    = 5'd9;
        @(negedge clk);
        bus.i_valid = 1'b0;
        chk("kill_start", bus.o_div_valid, 1);
        if (where != 0) @(negedge clk);
        bus.i_kill      = 1'b1;
        bus.i_div_ready = (where == 2);
        @(negedge clk);
        bus.i_kill      = 1'b0;
        bus.i_div_ready = 1'b0;
        if (where == 2) begin
            chk("kill_done_ready", bus.o_ready, 1);
            chk("kill_done_valid", bus.o_valid, 0);
        end else begin
            repeat (3) begin
                chk("drain_not_ready", bus.o_ready, 0);
                chk("drain_no_valid", bus.o_valid, 0);
                chk("drain_no_start", bus.o_div_valid, 0);
                @(negedge clk);
            end
            bus.i_div_ready = 1'b1;
            bus.i_div_q     = 32'd10;
            @(negedge clk);
            bus.i_div_ready = 1'b0;
            chk("drain_exit_ready", bus.o_ready, 1);
            chk("drain_exit_valid", bus.o_valid, 0);
        end
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        bus.i_valid     = 1'b0;
        bus.i_funct3    = 3'b000;
        bus.i_rs1       = '0;
        bus.i_rs2       = '0;
        bus.i_tag       = '0;
        bus.i_kill      = 1'b0;
        bus.i_res_ready = 1'b0;
        bus.i_div_ready = 1'b0;
        bus.i_div_q     = '0;
        bus.i_div_r     = '0;

        // Reset values
        #12;
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_div_valid", bus.o_div_valid, 0);
        chk("rst_illegal", bus.o_illegal, 0);
        chk("rst_result", bus.o_result, 0);
        chk("rst_tag", bus.o_tag, 0);
        chk("rst_dividend", bus.o_dividend, 0);
        chk("rst_divisor", bus.o_divisor, 0);
        chk("rst_sign", bus.o_div_sign, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Spurious divider done in IDLE
        @(negedge clk);
        bus.i_div_ready = 1'b1;
        @(negedge clk);
        bus.i_div_ready = 1'b0;
        chk("spurious_no_valid", bus.o_valid, 0);
        chk("spurious_ready", bus.o_ready, 1);

        // Directed cases
        run_req(3'b100, 32'hFFFF_FFEC, 32'd3, 5'd3, 1, 0);
        run_req(3'b111, 32'd7, 32'd0, 5'd4, 0, 0);
        run_req(3'b101, 32'd7, 32'd0, 5'd5, 0, 1);
        run_req(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0, 0);
        run_req(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0, 0);
        run_req(3'b101, 32'd100, 32'd7, 5'd8, 2, 5);
        run_kill(1);
        run_req(3'b110, 32'd10, 32'd4, 5'd10, 0, 0);
        run_kill(0);
        run_kill(2);
        run_req(3'b000, 32'd123, 32'd45, 5'd11, 0, 0);
        run_req(3'b011, 32'd1, 32'd0, 5'd12, 0, 1);

        // Kill in RESP wins over a same-cycle handshake
        @(negedge clk);
        bus.i_valid  = 1'b1;
        bus.i_funct3 = 3'b101;
        bus.i_rs1    = 32'd1;
        bus.i_rs2    = 32'd0;
        @(negedge clk);
        bus.i_valid = 1'b0;
        chk("kresp_valid", bus.o_valid, 1);
        bus.i_kill      = 1'b1;
        bus.i_res_ready = 1'b1;
        @(negedge clk);
        bus.i_kill      = 1'b0;
        bus.i_res_ready = 1'b0;
        chk("kresp_dropped", bus.o_valid, 0);
        chk("kresp_ready", bus.o_ready, 1);

        // Randomized requests with biased special operands
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                default: ;
            endcase
            run_req(f3, a, b, TW'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Asynchronous reset during DIV_WAIT
        @(negedge clk);
        bus.i_valid  = 1'b1;
        bus.i_funct3 = 3'b100;
        bus.i_rs1    = 32'h1234_5678;
        bus.i_rs2    = 32'd9;
        bus.i_tag    = 5'd17;
        @(negedge clk);
        bus.i_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_sign", bus.o_div_sign, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dividend", bus.o_dividend, 0);
        chk("arst_divisor", bus.o_divisor, 0);
        chk("arst_sign", bus.o_div_sign, 0);
        chk("arst_tag", bus.o_tag, 0);
        chk("arst_valid", bus.o_valid, 0);
        chk("arst_div_valid", bus.o_div_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bus.o_ready, 1);
        chk("post_rst_valid", bus.o_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
